// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared encodings and default vectors for the MIPS32 PC unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Next-PC source select encodings.
    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JR     = 2'd3
    } npc_sel_e;

    // Default vectors (zero-extended to WIDTH at the point of use).
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack used for fetch prediction.
//               A push into a full stack overwrites the oldest entry. A pop
//               from an empty stack is ignored. Push and pop together replace
//               the top entry, or act as a plain push when the stack is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_valid
);

    localparam int              PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int              CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state for the stack: the pointer wraps naturally since depth is a power of two.
    always_comb begin
        mem_d = mem_q;
        top_d = top_q;
        cnt_d = cnt_q;
        if (i_en) begin
            if (i_push && i_pop && (cnt_q != '0)) begin
                mem_d[top_q] = i_data;
            end else if (i_push) begin
                top_d        = top_q + PTR_W'(1);
                mem_d[top_d] = i_data;
                if (cnt_q != FULL) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (i_pop && (cnt_q != '0)) begin
                top_d = top_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Stack registers; reset empties the stack and clears storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign o_top   = mem_q[top_q];
    assign o_valid = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : MIPS32 fetch-stage program counter: next-PC selection,
//               stall, exception redirect with EPC capture, eret, and a
//               misaligned-JR trap. Optional return-address stack enabled
//               by defining PC_RAS_EN; without it ras_top/ras_valid are 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_wr,
    input  logic [1:0]       npc_sel,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_offset,
    input  logic [25:0]      jump_index,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic             is_call,
    input  logic             is_ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic             addr_err,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_valid
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             addr_err_q, addr_err_d;

    logic [WIDTH-1:0] pc_plus4_w;
    logic [WIDTH-1:0] jump_tgt;
    logic [WIDTH-1:0] npc;
    logic             jr_misaligned;
    logic             advance;

    assign pc_plus4_w = pc_q + WIDTH'(4);

    // Jump target keeps the upper region bits of pc+4 when the PC is wider than 28 bits.
    generate
        if (WIDTH > 28) begin : g_jump_region
            assign jump_tgt = {pc_plus4_w[WIDTH-1:28], jump_index, 2'b00};
        end else begin : g_jump_flat
            assign jump_tgt = {jump_index, 2'b00};
        end
    endgenerate

    // Next-PC mux for normal advance.
    always_comb begin
        npc = pc_plus4_w;
        case (npc_sel_e'(npc_sel))
            NPC_SEQ:    npc = pc_plus4_w;
            NPC_BRANCH: npc = br_taken ? (pc_plus4_w + br_offset) : pc_plus4_w;
            NPC_JUMP:   npc = jump_tgt;
            NPC_JR:     npc = jr_target;
            default:    npc = pc_plus4_w;
        endcase
    end

    assign jr_misaligned = pc_wr && (npc_sel == NPC_JR) && (jr_target[1:0] != 2'b00);

    // Update priority: exception > misaligned JR trap > eret > advance > hold.
    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        addr_err_d = 1'b0;
        advance    = 1'b0;
        if (exc_req) begin
            pc_d  = EXC_VEC;
            epc_d = pc_q;
        end else if (jr_misaligned) begin
            pc_d       = EXC_VEC;
            epc_d      = pc_q;
            addr_err_d = 1'b1;
        end else if (eret) begin
            pc_d = epc_q;
        end else if (pc_wr) begin
            pc_d    = npc;
            advance = 1'b1;
        end
    end

    // PC, EPC and trap-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_w;
    assign epc      = epc_q;
    assign addr_err = addr_err_q;

`ifdef PC_RAS_EN
    // RAS follows only normally advancing cycles; it never steers the PC.
    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .i_en    (advance),
        .i_push  (is_call),
        .i_pop   (is_ret),
        .i_data  (pc_plus4_w),
        .o_top   (ras_top),
        .o_valid (ras_valid)
    );
`else
    logic unused_ras_in;
    assign unused_ras_in = ^{is_call, is_ret, advance, 32'(RAS_DEPTH)};
    assign ras_top       = '0;
    assign ras_valid     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Self-checking bench for pc_unit: directed scenarios with
//               hand-computed values plus randomized traffic compared each
//               cycle against a behavioural model (PC_RAS_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    localparam int          W     = 32;
    localparam logic [31:0] RV    = 32'h0000_3000;
    localparam logic [31:0] EV    = 32'h0000_4180;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, pc_wr, br_taken, exc_req, eret, is_call, is_ret;
    logic [1:0]  npc_sel;
    logic [31:0] br_offset, jr_target;
    logic [25:0] jump_index;
    logic [31:0] pc, pc_plus4, epc, ras_top;
    logic        addr_err, ras_valid;

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH     (W),
        .RESET_VEC (RV),
        .EXC_VEC   (EV),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_wr      (pc_wr),
        .npc_sel    (npc_sel),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .jump_index (jump_index),
        .jr_target  (jr_target),
        .exc_req    (exc_req),
        .eret       (eret),
        .is_call    (is_call),
        .is_ret     (is_ret),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .epc        (epc),
        .addr_err   (addr_err),
        .ras_top    (ras_top),
        .ras_valid  (ras_valid)
    );

    // Behavioural model state
    logic [31:0] m_pc, m_epc;
    logic        m_err;
    logic [31:0] m_ras [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural next state from the current inputs.
    task automatic model_step();
        logic [31:0] p4, nxt;
        p4 = m_pc + 32'd4;
        if (reset) begin
            m_pc  = RV;
            m_epc = 32'd0;
            m_err = 1'b0;
            m_ras.delete();
        end else if (exc_req) begin
            m_epc = m_pc;
            m_pc  = EV;
            m_err = 1'b0;
        end else if (pc_wr && npc_sel == 2'd3 && jr_target[1:0] != 2'b00) begin
            m_epc = m_pc;
            m_pc  = EV;
            m_err = 1'b1;
        end else if (eret) begin
            m_pc  = m_epc;
            m_err = 1'b0;
        end else if (pc_wr) begin
            case (npc_sel)
                2'd0:    nxt = p4;
                2'd1:    nxt = br_taken ? p4 + br_offset : p4;
                2'd2:    nxt = (p4 & 32'hF000_0000) | ({6'd0, jump_index} * 32'd4);
                default: nxt = jr_target;
            endcase
`ifdef PC_RAS_EN
            if (is_call && is_ret && m_ras.size() != 0) begin
                m_ras[m_ras.size()-1] = p4;
            end else if (is_call) begin
                m_ras.push_back(p4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (is_ret && m_ras.size() != 0) begin
                void'(m_ras.pop_back());
            end
`endif
            m_pc  = nxt;
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("epc", epc, m_epc);
        chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
`ifdef PC_RAS_EN
        chk("ras_valid", {31'd0, ras_valid}, {31'd0, (m_ras.size() != 0)});
        if (m_ras.size() != 0) chk("ras_top", ras_top, m_ras[m_ras.size()-1]);
`else
        chk("ras_valid", {31'd0, ras_valid}, 32'd0);
        chk("ras_top", ras_top, 32'd0);
`endif
    endtask

    // One clock: model advances, DUT samples on posedge, outputs checked 1 time unit later.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_idle();
        reset = 1'b0; pc_wr = 1'b1; npc_sel = 2'd0; br_taken = 1'b0;
        br_offset = 32'd0; jump_index = 26'd0; jr_target = 32'd0;
        exc_req = 1'b0; eret = 1'b0; is_call = 1'b0; is_ret = 1'b0;
    endtask

    task automatic jr_to(input logic [31:0] a);
        set_idle(); npc_sel = 2'd3; jr_target = a; step();
    endtask

    logic [31:0] exp_ret [4];

    initial begin
        m_pc = 32'd0; m_epc = 32'd0; m_err = 1'b0;
        exp_ret = '{32'h3014, 32'h3010, 32'h300C, 32'h3008};

        // 1: reset and sequential advance
        set_idle(); reset = 1'b1;
        step(); step();
        chk("t1_reset_pc", pc, 32'h3000);
        chk("t1_reset_epc", epc, 32'h0);
        chk("t1_reset_err", {31'd0, addr_err}, 32'd0);
        set_idle();
        step(); chk("t1_seq1", pc, 32'h3004);
        step(); chk("t1_seq2", pc, 32'h3008);
        step(); chk("t1_seq3", pc, 32'h300C);
        step(); chk("t1_seq4", pc, 32'h3010);

        // 2: branch taken / not taken, jump, stall
        set_idle(); npc_sel = 2'd1; br_taken = 1'b1; br_offset = 32'hFFFF_FFF0;
        step(); chk("t2_br_taken", pc, 32'h3004);
        jr_to(32'h3010);
        set_idle(); npc_sel = 2'd1; br_taken = 1'b0; br_offset = 32'hFFFF_FFF0;
        step(); chk("t2_br_not", pc, 32'h3014);
        jr_to(32'h3020);
        set_idle(); npc_sel = 2'd2; jump_index = 26'h0000C40;
        step(); chk("t2_jump", pc, 32'h3100);
        set_idle(); pc_wr = 1'b0; npc_sel = 2'd2; jump_index = 26'h3FFFFFF;
        for (int k = 0; k < 3; k++) begin
            step(); chk("t2_stall", pc, 32'h3100);
        end

        // 3: exception while stalled, eret, exception beats eret
        jr_to(32'h3040);
        set_idle(); pc_wr = 1'b0; exc_req = 1'b1;
        step(); chk("t3_exc_pc", pc, 32'h4180); chk("t3_exc_epc", epc, 32'h3040);
        set_idle(); pc_wr = 1'b0; eret = 1'b1;
        step(); chk("t3_eret", pc, 32'h3040); chk("t3_eret_epc", epc, 32'h3040);
        set_idle(); exc_req = 1'b1; eret = 1'b1;
        step(); chk("t3_exc_eret", pc, 32'h4180);

        // 4: misaligned JR trap
        jr_to(32'h3050);
        jr_to(32'h3102);
        chk("t4_trap_pc", pc, 32'h4180);
        chk("t4_trap_epc", epc, 32'h3050);
        chk("t4_err_hi", {31'd0, addr_err}, 32'd1);
        set_idle();
        step(); chk("t4_err_lo", {31'd0, addr_err}, 32'd0);

        // 5: return-address stack
        set_idle(); reset = 1'b1; step();
        set_idle(); is_call = 1'b1;
        for (int k = 0; k < 5; k++) step();
`ifdef PC_RAS_EN
        chk("t5_top", ras_top, 32'h3014);
        for (int k = 0; k < 4; k++) begin
            chk("t5_ret", ras_top, exp_ret[k]);
            set_idle(); is_ret = 1'b1; step();
        end
        chk("t5_empty", {31'd0, ras_valid}, 32'd0);
        set_idle(); is_ret = 1'b1; step();
        chk("t5_pop_empty", {31'd0, ras_valid}, 32'd0);
`else
        chk("t5_no_ras", {31'd0, ras_valid}, 32'd0);
`endif

        // 6: wrap, then reset during stall
        jr_to(32'hFFFF_FFFC);
        set_idle();
        step(); chk("t6_wrap", pc, 32'h0000_0000);
        set_idle(); pc_wr = 1'b0;
        step();
        set_idle(); pc_wr = 1'b0; reset = 1'b1;
        step(); chk("t6_reset_stall", pc, 32'h3000);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(63) == 0);
            pc_wr      = ($urandom_range(3) != 0);
            npc_sel    = 2'($urandom_range(3));
            br_taken   = $urandom_range(1) == 1;
            br_offset  = $urandom & 32'hFFFF_FFFC;
            jump_index = 26'($urandom);
            jr_target  = $urandom;
            if ($urandom_range(7) != 0) jr_target[1:0] = 2'b00;
            exc_req    = ($urandom_range(15) == 0);
            eret       = ($urandom_range(15) == 0);
            is_call    = ($urandom_range(3) == 0);
            is_ret     = ($urandom_range(3) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
